// File: rtl/e_expand_pipe.sv
// E-expansion stage: expands each 4-bit group of R to 6 bits with wrap-around edge bits; optional subkey XOR (E_EXPAND_KEYMIX_EN).
// Latency: 1 cycle from input accept to out_valid; throughput 1 word/cycle.
// Backpressure: 2-entry output FIFO; in_ready = (occupancy < 2), independent of out_ready.
module e_expand_pipe #(
    parameter  int HALF_W = 64,
    localparam int EW     = HALF_W * 3 / 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [HALF_W-1:0] i_in_r,
    input  logic [EW-1:0] i_in_k,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [EW-1:0] o_out_data,
    output logic [1:0]    o_occupancy
);
    localparam int G = HALF_W / 4;

    logic [EW-1:0] w_exp;
    logic [EW-1:0] w_word;
    logic          w_push;
    logic          w_pop;

    logic [EW-1:0] r_mem [2];
    logic          r_head;
    logic          r_tail;
    logic [1:0]    r_count;

    // Each group takes its own 4 bits plus one borrowed bit from each neighbour,
    // wrapping from R0 back to R[HALF_W-1] and vice versa.
    for (genvar g = 0; g < G; g++) begin : g_grp
        localparam int B = EW - 1 - 6 * g;
        assign w_exp[B]     = i_in_r[(HALF_W - 4 * g) % HALF_W];
        assign w_exp[B - 1] = i_in_r[HALF_W - 1 - 4 * g];
        assign w_exp[B - 2] = i_in_r[HALF_W - 2 - 4 * g];
        assign w_exp[B - 3] = i_in_r[HALF_W - 3 - 4 * g];
        assign w_exp[B - 4] = i_in_r[HALF_W - 4 - 4 * g];
        assign w_exp[B - 5] = i_in_r[(2 * HALF_W - 5 - 4 * g) % HALF_W];
    end

`ifdef E_EXPAND_KEYMIX_EN
    assign w_word = w_exp ^ i_in_k;
`else
    // Subkey port kept for a uniform interface; it feeds nothing.
    logic w_unused_k;
    assign w_unused_k = ^i_in_k;
    assign w_word     = w_exp;
`endif

    assign o_in_ready  = (r_count != 2'd2);
    assign o_out_valid = (r_count != 2'd0);
    assign o_occupancy = r_count;
    assign o_out_data  = r_mem[r_head];

    assign w_push = i_in_valid & o_in_ready;
    assign w_pop  = o_out_valid & i_out_ready;

    // FIFO state: clr beats push/pop; storage is don't-care after clr.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clr) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= w_word;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: doc/e_expand_pipe.md
# e_expand_pipe

Registered, parametrised E-expansion stage for the widened DES datapath. Takes a HALF_W-bit right half-block, expands every 4-bit group to 6 bits by borrowing the neighbouring edge bits with wrap-around, and optionally XORs the result with the round subkey. The block sits between the round-half register and the S-box bank. A 2-entry valid/ready output buffer lets the S-box stage stall without losing data.

## Interface
- HALF_W, 64, half-block width in bits; multiple of 4, at least 8; output width EW = HALF_W*3/2 (96 at default)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush of buffer contents; does not affect configuration
- in_valid  in  1  input half-block valid
- in_ready  out  1  block can accept a half-block this cycle
- in_r  in  HALF_W  right half-block R
- in_k  in  EW  round subkey; used only with E_EXPAND_KEYMIX_EN
- out_valid  out  1  out_data holds a valid expanded word
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  EW  expanded (and optionally key-mixed) word
- occupancy  out  2  number of stored entries, 0..2

## Operation
- G = HALF_W/4 groups. Group g=0 occupies out bits [EW-1:EW-6]; group g occupies [EW-1-6g : EW-6-6g].
- Group g, MSB to LSB: R[(HALF_W-4g) mod HALF_W], R[HALF_W-1-4g], R[HALF_W-2-4g], R[HALF_W-3-4g], R[HALF_W-4-4g], R[(HALF_W-5-4g+HALF_W) mod HALF_W].
- At HALF_W=64: group 0 = {R0,R63..R59}; group 15 = {R4,R3..R0,R63}.
- Expansion and optional key XOR are computed combinationally on in_r/in_k. The result is written into the buffer on input acceptance (in_valid & in_ready).
- Buffer: 2-entry FIFO with head/tail pointers and a 2-bit count. out_data always presents the head entry.
- Input accepted when in_valid & in_ready. Output consumed when out_valid & out_ready.
- in_ready = (occupancy < 2). It does not depend on out_ready, so there is no combinational ready path.
- Simultaneous accept and consume: occupancy is unchanged, and FIFO order is preserved. This includes occupancy 1, where the new entry becomes the head next cycle.
- Accept at occupancy 0 while out_ready is high: the entry still takes 1 cycle. There is no same-cycle bypass.
- clr: occupancy → 0 and out_valid → 0 next cycle. An input offered in the same cycle is dropped. clr has priority over accept and consume.
- out_data is held stable while out_valid & !out_ready.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word/cycle with out_ready held high.
- Reset values: out_valid=0, occupancy=0, in_ready=1, out_data=0, pointers=0.
- Storage contents are cleared to 0 on reset. They are don't-care after clr.
- Reset mid-operation: all entries are discarded immediately (asynchronous). The first accept after rst_n deassertion is on the next rising edge.
- When full (occupancy=2), in_ready=0. in_valid is ignored, and in_r is not sampled.
- When empty, out_valid=0. out_ready is ignored.

## Configuration
- E_EXPAND_KEYMIX_EN defined: each stored word = E(in_r) XOR in_k, and in_k is sampled on accept.
- E_EXPAND_KEYMIX_EN undefined: each stored word = E(in_r). The in_k port remains but is unused and is not connected internally.

## Test plan
- Basic map, KEYMIX off, HALF_W=64:
  - in_r=64'h0000_0000_0000_0001 → out_data=96'h8000_0000_0000_0000_0000_0002 one cycle after accept.
  - in_r=64'h8000_0000_0000_0000 → 96'h4000_0000_0000_0000_0000_0001.
- Key mix, KEYMIX on: in_r=64'h0000_0000_0000_0001, in_k=96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF → out_data=96'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFD.
- Backpressure: out_ready=0 while 3 words A, B, C are offered.
  - A and B are accepted; occupancy=2, in_ready=0, and C is held.
  - Set out_ready=1 → A, B, C emerge in order, with out_data stable while stalled.
- Streaming: in_valid=1 and out_ready=1 for 16 cycles with an incrementing in_r → 16 outputs on consecutive cycles, each 1 cycle after its input, with occupancy ≤1.
- Flush and reset:
  - At occupancy=2, assert clr with in_valid=1 → occupancy=0 and out_valid=0 next cycle, and the offered word is lost.
  - Assert rst_n low asynchronously mid-stream → out_valid drops without waiting for a clock edge.
- Width: HALF_W=8, in_r=8'h01 → out_data=12'h802 (group 0 = {R0,R7..R3}, group 1 = {R4,R3..R0,R7}).
